// File: rtl/product_acc_pkg.sv
// rtl/product_acc_pkg.sv - shared types and constants for the product accumulator
package product_acc_pkg;

    localparam int PRODUCT_W = 16;
    localparam int COUNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational unsigned saturating adder with carry-out flag
module sat_add #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] raw;

    // Full-width add; clamp to all-ones when the carry shows overflow
    always_comb begin
        raw   = {1'b0, a} + {1'b0, b};
        carry = raw[W];
        sum   = raw[W] ? {W{1'b1}} : raw[W-1:0];
    end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - frames unsigned products into a saturated sum with count
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRODUCT_W-1:0] in_product,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [COUNT_W-1:0]   out_count,
    output logic                 out_sat
);

    acc_state_e         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               sat_q, sat_d;

    logic               beat;
    logic               frame_end;
    logic [COUNT_W-1:0] count_inc;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;

    assign prod_ext = {{(ACC_W-PRODUCT_W){1'b0}}, in_product};

    sat_add #(
        .W(ACC_W)
    ) u_sat_add (
        .a    (acc_q),
        .b    (prod_ext),
        .sum  (add_sum),
        .carry(add_carry)
    );

    // Next-state and accumulator update; only a beat touches acc/count/sat
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        sat_d     = sat_q;
        frame_end = 1'b0;
        in_ready  = (state_q != HOLD);
        beat      = in_valid && in_ready;
        count_inc = count_q + COUNT_W'(1);

        case (state_q)
            IDLE: begin
                if (beat) begin
                    // First product loads directly so an old frame's sum never leaks in
                    acc_d     = prod_ext;
                    count_d   = COUNT_W'(1);
                    sat_d     = 1'b0;
                    frame_end = in_last;
                    state_d   = frame_end ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d     = add_sum;
                    count_d   = count_inc;
                    sat_d     = sat_q | add_carry;
                    // in_last and the length limit may coincide; either ends the frame once
                    frame_end = in_last || (count_inc == COUNT_W'(MAX_LEN));
                    state_d   = frame_end ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so a partial frame is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    // Result comes straight from registers; acc/count/sat are frozen while in HOLD
    always_comb begin
        out_valid = (state_q == HOLD);
        out_sum   = acc_q;
        out_count = count_q;
        out_sat   = sat_q;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator across three parameter sets
module tb_product_accumulator;

    typedef struct {
        int          inst;
        logic [31:0] sum;
        int          cnt;
        logic        sat;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] in_product;
    logic        in_last;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  osat;
    logic [23:0] osum [3];
    logic [7:0]  ocnt [3];
    logic [23:0] sum0, sum2;
    logic [16:0] sum1;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    longint m_acc [3];
    int     m_cnt [3];
    bit     m_sat [3];
    bit     m_act [3];
    int     AW [3] = '{24, 17, 24};
    int     ML [3] = '{8, 8, 4};

    always #5 clk = ~clk;

    product_accumulator u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_product(in_product), .in_last(in_last), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_sum(sum0), .out_count(ocnt[0]), .out_sat(osat[0])
    );

    product_accumulator #(.ACC_W(17)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_product(in_product), .in_last(in_last), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_sum(sum1), .out_count(ocnt[1]), .out_sat(osat[1])
    );

    product_accumulator #(.MAX_LEN(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_product(in_product), .in_last(in_last), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_sum(sum2), .out_count(ocnt[2]), .out_sat(osat[2])
    );

    assign osum[0] = sum0;
    assign osum[1] = {7'd0, sum1};
    assign osum[2] = sum2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_act[i] = 0;
        end
    endtask

    task automatic model_beat(input int i, input int prod, input bit last);
        longint mx;
        longint s;
        exp_t e;
        mx = (64'd1 << AW[i]) - 1;
        if (!m_act[i]) begin
            m_acc[i] = prod; m_cnt[i] = 1; m_sat[i] = 0; m_act[i] = 1;
        end else begin
            s = m_acc[i] + prod;
            if (s > mx) begin
                m_acc[i] = mx; m_sat[i] = 1;
            end else begin
                m_acc[i] = s;
            end
            m_cnt[i]++;
        end
        if (last || m_cnt[i] == ML[i]) begin
            e.inst = i; e.sum = m_acc[i][31:0]; e.cnt = m_cnt[i]; e.sat = m_sat[i];
            sb.push_back(e);
            m_act[i] = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the beat edge
    task automatic send(input int i, input int prod, input bit last);
        int n = 0;
        in_product = prod[15:0];
        in_last    = last;
        iv[i]      = 1'b1;
        @(negedge clk);
        while (!ir[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, ir[i]}, 32'd1);
        @(posedge clk);
        #1;
        iv[i]   = 1'b0;
        in_last = 1'b0;
        model_beat(i, prod, last);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every output handshake must match the oldest expected result
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && ov[i] && ordy[i]) begin
                chk("result_expected", {31'd0, (sb.size() > 0 && sb[0].inst == i)}, 32'd1);
                if (sb.size() > 0 && sb[0].inst == i) begin
                    mon_e = sb.pop_front();
                    chk("sb_sum",   {8'd0, osum[i]}, mon_e.sum);
                    chk("sb_count", {24'd0, ocnt[i]}, mon_e.cnt);
                    chk("sb_sat",   {31'd0, osat[i]}, {31'd0, mon_e.sat});
                end
            end
        end
    end

    initial begin
        iv = 3'b000; ordy = 3'b111; in_product = 16'd0; in_last = 1'b0;
        model_reset();

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {29'd0, ov}, 32'd0);
        chk("rst_out_sum",   {8'd0, osum[0]}, 32'd0);
        chk("rst_out_count", {24'd0, ocnt[0]}, 32'd0);
        chk("rst_out_sat",   {29'd0, osat}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {29'd0, ir}, 32'd7);

        // Eight beats of 0xFE01 end the frame on the length limit
        for (int k = 0; k < 7; k++) send(0, 16'hFE01, 1'b0);
        chk("no_early_valid", {31'd0, ov[0]}, 32'd0);
        send(0, 16'hFE01, 1'b0);
        chk("t1_valid_latency", {31'd0, ov[0]}, 32'd1);
        chk("t1_sum",   {8'd0, osum[0]}, 32'h07F008);
        chk("t1_count", {24'd0, ocnt[0]}, 32'd8);
        chk("t1_sat",   {31'd0, osat[0]}, 32'd0);
        drain();

        // Short frame terminated by in_last
        send(0, 10, 1'b0);
        send(0, 20, 1'b0);
        send(0, 30, 1'b1);
        chk("t2_sum",   {8'd0, osum[0]}, 32'd60);
        chk("t2_count", {24'd0, ocnt[0]}, 32'd3);
        chk("t2_sat",   {31'd0, osat[0]}, 32'd0);
        drain();

        // Saturation with a 17-bit accumulator
        for (int k = 0; k < 3; k++) send(1, 16'hFE01, k == 2);
        chk("t3_sum",   {8'd0, osum[1]}, 32'h1FFFF);
        chk("t3_count", {24'd0, ocnt[1]}, 32'd3);
        chk("t3_sat",   {31'd0, osat[1]}, 32'd1);
        drain();

        // Back-pressure: result held, upstream blocked
        ordy[0] = 1'b0;
        send(0, 100, 1'b0);
        send(0, 200, 1'b1);
        iv[0] = 1'b1; in_product = 16'h1234; in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t4_in_ready", {31'd0, ir[0]}, 32'd0);
            chk("t4_valid",    {31'd0, ov[0]}, 32'd1);
            chk("t4_sum",      {8'd0, osum[0]}, 32'd300);
            chk("t4_count",    {24'd0, ocnt[0]}, 32'd2);
        end
        @(posedge clk);
        #1 iv[0] = 1'b0; in_last = 1'b0; ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_valid_drop", {31'd0, ov[0]}, 32'd0);
        chk("t4_idle_ready", {31'd0, ir[0]}, 32'd1);
        chk("t4_sb_empty", sb.size(), 0);

        // Reset mid-frame discards the partial sum
        send(0, 7, 1'b0);
        send(0, 9, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_sum",   {8'd0, osum[0]}, 32'd0);
        chk("t5_rst_count", {24'd0, ocnt[0]}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(0, 5, 1'b1);
        chk("t5_sum",   {8'd0, osum[0]}, 32'd5);
        chk("t5_count", {24'd0, ocnt[0]}, 32'd1);
        drain();
        idle_cycles(3);
        chk("t5_no_extra", {31'd0, ov[0]}, 32'd0);

        // MAX_LEN=4 with in_last on the limiting beat
        ordy[2] = 1'b0;
        for (int k = 1; k <= 4; k++) send(2, k, k == 4);
        chk("t6_valid", {31'd0, ov[2]}, 32'd1);
        chk("t6_count", {24'd0, ocnt[2]}, 32'd4);
        repeat (2) begin
            @(negedge clk);
            chk("t6_blocked", {31'd0, ir[2]}, 32'd0);
        end
        @(posedge clk);
        #1 ordy[2] = 1'b1;
        drain();
        idle_cycles(3);
        chk("t6_single_result", {31'd0, ov[2]}, 32'd0);

        // Length limit without in_last rolls into a new frame
        for (int k = 0; k < 4; k++) send(2, 1000, 1'b0);
        send(2, 7, 1'b1);
        drain();

        // Random products with random frame boundaries
        for (int k = 0; k < 20; k++) send(0, $urandom_range(0, 65535), (k == 19) || ($urandom_range(0, 3) == 0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator and result width in bits (minimum 17).
REQ-002 SHALL have parameter MAX_LEN, default 8, the maximum number of products per frame (2..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, an upstream product is present.
REQ-006 SHALL have port in_ready, output, 1, the block can accept a product this cycle.
REQ-007 SHALL have port in_product, input, 16, the unsigned 16-bit product from the upstream 8x8 multiplier.
REQ-008 SHALL have port in_last, input, 1, marks the final product of a frame; qualified by in_valid.
REQ-009 SHALL have port out_valid, output, 1, the frame result is present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port out_sum, output, ACC_W, the saturated unsigned sum of the frame.
REQ-012 SHALL have port out_count, output, 8, the number of products accumulated in the frame (1..MAX_LEN).
REQ-013 SHALL have port out_sat, output, 1, set if any addition in the frame saturated.

Function
REQ-014 SHALL define a beat as a cycle with in_valid=1 and in_ready=1; no other cycle changes the accumulator.
REQ-015 SHALL implement the states IDLE, ACCUM and HOLD.
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-017 SHALL, on a beat in IDLE, load acc=in_product, set count=1, clear sat, and go to ACCUM, without ever adding a stale sum.
REQ-018 SHALL, on a beat in ACCUM, set acc to the saturating sum acc+in_product zero-extended, and increment count.
REQ-019 SHALL saturate: when the true sum exceeds 2^ACC_W-1, acc SHALL become 2^ACC_W-1 and sat SHALL be set; sat is sticky until the next frame.
REQ-020 SHALL end the frame on a beat with in_last=1 or on the beat that makes count reach MAX_LEN; both together SHALL produce exactly one result.
REQ-021 SHALL, on the frame-ending beat (including a single-beat frame from IDLE), go to HOLD and assert out_valid on the next cycle, giving one cycle of latency from the final beat.
REQ-022 SHALL hold out_valid, out_sum, out_count and out_sat stable in HOLD until out_valid and out_ready are both 1.
REQ-023 SHALL, on the output handshake, deassert out_valid and return to IDLE; the next beat is accepted no earlier than the following cycle.
REQ-024 SHALL ignore in_product and in_last when in_valid=0.
REQ-025 SHALL drive out_sum, out_count and out_sat from registers only, with no combinational path from in_* to out_*.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, acc=0, count=0, sat=0, out_valid=0, out_sum=0, out_count=0 and out_sat=0, regardless of clk.
REQ-027 SHALL, on reset mid-frame or in HOLD, discard the partial frame or pending result; no result is emitted for it after release.
REQ-028 SHALL drive in_ready=1 from the first clock edge after rst_n deasserts.

Structure
REQ-029 SHALL place the state enum (IDLE, ACCUM, HOLD) and the default constants PRODUCT_W=16 and COUNT_W=8 in the shared package product_acc_pkg.
REQ-030 SHALL contain one sub-module, sat_add, a combinational ACC_W-bit unsigned saturating adder with a carry-out flag; all other logic stays in product_accumulator.

Verification
REQ-031 SHALL cover: defaults, 8 beats of 0xFE01, out_ready=1 -> out_sum=0x07F008, out_count=8, out_sat=0, with out_valid one cycle after beat 8.
REQ-032 SHALL cover: beats 10, 20, 30 with in_last on the 3rd -> out_sum=60, out_count=3, out_sat=0.
REQ-033 SHALL cover: ACC_W=17, 3 beats of 0xFE01 with in_last on the 3rd -> out_sum=0x1FFFF, out_sat=1, out_count=3.
REQ-034 SHALL cover: result pending with out_ready=0 for 5 cycles and in_valid=1 -> outputs stable, in_ready=0, no beat accepted; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover: rst_n pulsed low after 2 beats (7, 9), then a single beat of 5 with in_last -> out_sum=5, out_count=1, and no result for the aborted frame.
REQ-036 SHALL cover: MAX_LEN=4 with in_last=1 on the 4th beat -> exactly one result with out_count=4, and in_ready=0 until that result is taken.
